// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter and its selector.
package mem_port_arbiter_pkg;

    localparam int MAX_CLIENTS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Combinational requester selector: fixed priority or round-robin from a pointer.
module rr_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter bit RR_MODE     = 1'b1,
    localparam int IDX_W      = clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [IDX_W-1:0]       idx,
    output logic                   valid
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_CLIENTS);

    logic [IDX_W-1:0]       start;
    logic [NUM_CLIENTS-1:0] req_rot;
    logic [IDX_W-1:0]       off;
    logic [IDX_W:0]         sum;

    // Rotating the request vector so the search always scans from bit 0.
    assign start   = RR_MODE ? ptr : '0;
    assign req_rot = NUM_CLIENTS'({req, req} >> start);

    // First set bit of the rotated vector, mapped back to a client index.
    always_comb begin
        off   = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!valid && req_rot[i]) begin
                valid = 1'b1;
                off   = IDX_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        idx   = sum[IDX_W-1:0];
        grant = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            grant[i] = valid && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multi-client front-end onto one variable-latency memory port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transaction; arbitrate and latch the winner's request
// ST_WAIT | mem_req high, waiting for mem_ack or timeout
// ST_DONE | one-cycle cli_done (and cli_err on abort) to the winner
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter bit RR_MODE     = 1'b1,
    parameter int TIMEOUT_CYC = 1024,
    localparam int IDX_W      = clog2(NUM_CLIENTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        cli_req,
    input  logic [NUM_CLIENTS-1:0]        cli_we,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata,
    output logic [NUM_CLIENTS-1:0]        cli_done,
    output logic [NUM_CLIENTS-1:0]        cli_err,
    output logic [DATA_W-1:0]             cli_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_idx
);

    localparam int TMO_W = clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLIENTS - 1);

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [NUM_CLIENTS-1:0] gnt_oh;
    logic [NUM_CLIENTS-1:0] sel_grant;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_valid;
    logic                   timeout_hit;
    logic [ADDR_W-1:0]      addr_arr  [NUM_CLIENTS];
    logic [DATA_W-1:0]      wdata_arr [NUM_CLIENTS];

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
        assign addr_arr[g]  = cli_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = cli_wdata[g*DATA_W +: DATA_W];
    end

    rr_select #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .RR_MODE     (RR_MODE)
    ) u_rr_select (
        .req   (cli_req),
        .ptr   (rr_ptr),
        .grant (sel_grant),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // A zero TIMEOUT_CYC disables the abort path entirely.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

    // Arbitration FSM; every output is a register so mem_req drops on reset alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            tmo_cnt   <= '0;
            gnt_oh    <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cli_done  <= '0;
            cli_err   <= '0;
            cli_rdata <= '0;
        end else begin
            cli_done <= '0;
            cli_err  <= '0;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state     <= ST_WAIT;
                        grant_idx <= sel_idx;
                        gnt_oh    <= sel_grant;
                        rr_ptr    <= (sel_idx == IDX_LAST) ? '0 : sel_idx + IDX_W'(1);
                        mem_req   <= 1'b1;
                        mem_we    <= cli_we[sel_idx];
                        mem_addr  <= addr_arr[sel_idx];
                        mem_wdata <= wdata_arr[sel_idx];
                        tmo_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        state    <= ST_DONE;
                        mem_req  <= 1'b0;
                        cli_done <= gnt_oh;
                        if (!mem_we) begin
                            cli_rdata <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        state    <= ST_DONE;
                        mem_req  <= 1'b0;
                        cli_done <= gnt_oh;
                        cli_err  <= gnt_oh;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A is round-robin with a 16-cycle timeout,
// instance B is fixed priority with the timeout disabled.
module tb_mem_port_arbiter;

    localparam int NC = 3;
    localparam int AW = 19;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [NC-1:0]     cli_req = '0;
    logic [NC-1:0]     cli_we = '0;
    logic [NC*AW-1:0]  cli_addr = '0;
    logic [NC*DW-1:0]  cli_wdata = '0;

    logic [NC-1:0] done_a, err_a, done_b, err_b;
    logic [DW-1:0] rdata_a, rdata_b, mem_wdata_a, mem_wdata_b;
    logic [DW-1:0] mem_rdata_a = '0, mem_rdata_b = '0;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic          mem_req_a, mem_req_b, mem_we_a, mem_we_b, busy_a, busy_b;
    logic          mem_ack_a, mem_ack_b;
    logic [1:0]    gidx_a, gidx_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   auto_a = 0;
    int   auto_b = 1;
    int   cnt_a = 0;
    int   cnt_b = 0;
    logic man_ack_a = 1'b0;

    mem_port_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b1), .TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .rst(rst), .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr),
        .cli_wdata(cli_wdata), .cli_done(done_a), .cli_err(err_a), .cli_rdata(rdata_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_ack(mem_ack_a), .mem_rdata(mem_rdata_a), .busy(busy_a), .grant_idx(gidx_a)
    );

    mem_port_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b0), .TIMEOUT_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr),
        .cli_wdata(cli_wdata), .cli_done(done_b), .cli_err(err_b), .cli_rdata(rdata_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b), .busy(busy_b), .grant_idx(gidx_b)
    );

    // Memory models: ack in the auto_x-th cycle that mem_req is high (0 = never).
    initial begin
        mem_ack_a = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req_a) cnt_a++; else cnt_a = 0;
            mem_ack_a = man_ack_a || (auto_a != 0 && cnt_a == auto_a);
        end
    end

    initial begin
        mem_ack_b = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req_b) cnt_b++; else cnt_b = 0;
            mem_ack_b = (auto_b != 0 && cnt_b == auto_b);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_idx(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic apply_reset;
        rst = 1'b1;
        cli_req = '0;
        man_ack_a = 1'b0;
        auto_a = 0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        tick;
        tick;
        n_cmp++; if (mem_req_a !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_cmp++; if (gidx_a !== 2'd0) begin n_bad++; $display("FAIL reset_grant_idx: got %0d want 0", gidx_a); end
        n_cmp++; if (done_a !== 3'b000) begin n_bad++; $display("FAIL reset_done: got %b want 000", done_a); end
        n_cmp++; if (err_a !== 3'b000) begin n_bad++; $display("FAIL reset_err: got %b want 000", err_a); end
        n_cmp++; if (rdata_a !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata_a); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            n_cmp++; if (busy_a !== 1'b0 || mem_req_a !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: busy=%b mem_req=%b want 0/0", busy_a, mem_req_a); end
        end
    endtask

    task automatic test_single_read;
        int lat;
        lat = 0;
        auto_a = 5;
        mem_rdata_a = 8'hA5;
        cli_we[0] = 1'b0;
        cli_addr[0*AW +: AW] = 19'h00010;
        cli_req = 3'b001;
        for (int k = 1; k <= 30; k++) begin
            tick;
            if (k == 1) begin
                n_cmp++; if (mem_req_a !== 1'b1 || mem_addr_a !== 19'h00010 || mem_we_a !== 1'b0) begin
                    n_bad++; $display("FAIL read_issue: req=%b addr=%h we=%b want 1/00010/0", mem_req_a, mem_addr_a, mem_we_a);
                end
            end
            if (done_a != 3'b000) begin lat = k + 1; break; end
        end
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL read_latency: got %0d want 7", lat); end
        n_cmp++; if (done_a !== 3'b001) begin n_bad++; $display("FAIL read_done: got %b want 001", done_a); end
        n_cmp++; if (rdata_a !== 8'hA5) begin n_bad++; $display("FAIL read_rdata: got %h want a5", rdata_a); end
        n_cmp++; if (err_a !== 3'b000) begin n_bad++; $display("FAIL read_err: got %b want 000", err_a); end
        tick;
        cli_req = 3'b000;
        n_cmp++; if (done_a !== 3'b000) begin n_bad++; $display("FAIL read_done_width: got %b want 000", done_a); end
        tick;
    endtask

    task automatic test_single_write;
        int lat;
        lat = 0;
        auto_a = 3;
        mem_rdata_a = 8'h77;
        cli_we[1] = 1'b1;
        cli_addr[1*AW +: AW] = 19'h7FFFF;
        cli_wdata[1*DW +: DW] = 8'h3C;
        cli_req = 3'b010;
        for (int k = 1; k <= 30; k++) begin
            tick;
            if (k == 1) begin
                n_cmp++; if (mem_req_a !== 1'b1 || mem_we_a !== 1'b1 || mem_addr_a !== 19'h7FFFF || mem_wdata_a !== 8'h3C) begin
                    n_bad++; $display("FAIL write_issue: req=%b we=%b addr=%h wdata=%h want 1/1/7ffff/3c", mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a);
                end
                n_cmp++; if (gidx_a !== 2'd1) begin n_bad++; $display("FAIL write_grant_idx: got %0d want 1", gidx_a); end
            end
            if (done_a != 3'b000) begin lat = k + 1; break; end
        end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL write_latency: got %0d want 5", lat); end
        n_cmp++; if (done_a !== 3'b010) begin n_bad++; $display("FAIL write_done: got %b want 010", done_a); end
        n_cmp++; if (rdata_a !== 8'hA5) begin n_bad++; $display("FAIL write_rdata_hold: got %h want a5", rdata_a); end
        tick;
        cli_req = 3'b000;
        cli_we = 3'b000;
        tick;
    endtask

    task automatic test_back_to_back;
        int seq_a[$];
        int seq_b[$];
        int t_first, t_last, got;
        t_first = -1;
        t_last = -1;
        apply_reset;
        auto_a = 1;
        auto_b = 1;
        cli_req = 3'b111;
        for (int k = 1; k <= 200; k++) begin
            tick;
            if (done_a != 3'b000 && seq_a.size() < 9) begin
                seq_a.push_back(oh_idx(done_a));
                if (t_first < 0) t_first = k;
                t_last = k;
            end
            if (done_b != 3'b000 && seq_b.size() < 9) seq_b.push_back(oh_idx(done_b));
            if (seq_a.size() >= 9 && seq_b.size() >= 9) break;
        end
        for (int i = 0; i < 9; i++) begin
            got = (i < seq_a.size()) ? seq_a[i] : -1;
            n_cmp++; if (got !== i % 3) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got, i % 3); end
            got = (i < seq_b.size()) ? seq_b[i] : -1;
            n_cmp++; if (got !== 0) begin n_bad++; $display("FAIL fixed_order[%0d]: got %0d want 0", i, got); end
        end
        n_cmp++; if (t_last - t_first !== 24) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 24", t_last - t_first); end
        n_cmp++; if (err_b !== 3'b000) begin n_bad++; $display("FAIL fixed_err: got %b want 000", err_b); end
        cli_req = 3'b000;
        tick;
        tick;
        tick;
    endtask

    task automatic test_timeout;
        int req_cycles;
        bit seen;
        req_cycles = 0;
        seen = 1'b0;
        apply_reset;
        auto_a = 0;
        cli_we[2] = 1'b0;
        cli_addr[2*AW +: AW] = 19'h12345;
        cli_req = 3'b100;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (mem_req_a) req_cycles++;
            if (done_a != 3'b000) begin seen = 1'b1; break; end
        end
        n_cmp++; if (req_cycles !== 16) begin n_bad++; $display("FAIL tmo_req_cycles: got %0d want 16", req_cycles); end
        n_cmp++; if (seen !== 1'b1 || done_a !== 3'b100) begin n_bad++; $display("FAIL tmo_done: got %b want 100", done_a); end
        n_cmp++; if (err_a !== 3'b100) begin n_bad++; $display("FAIL tmo_err: got %b want 100", err_a); end
        n_cmp++; if (rdata_a !== 8'h00) begin n_bad++; $display("FAIL tmo_rdata_hold: got %h want 00", rdata_a); end
        tick;
        cli_req = 3'b001;
        cli_we[0] = 1'b0;
        auto_a = 2;
        mem_rdata_a = 8'h5A;
        n_cmp++; if (err_a !== 3'b000 || done_a !== 3'b000) begin n_bad++; $display("FAIL tmo_pulse_width: done=%b err=%b want 000/000", done_a, err_a); end
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (done_a != 3'b000) begin seen = 1'b1; break; end
        end
        n_cmp++; if (seen !== 1'b1 || done_a !== 3'b001 || err_a !== 3'b000) begin
            n_bad++; $display("FAIL tmo_next_req: done=%b err=%b want 001/000", done_a, err_a);
        end
        n_cmp++; if (rdata_a !== 8'h5A) begin n_bad++; $display("FAIL tmo_next_rdata: got %h want 5a", rdata_a); end
        tick;
        cli_req = 3'b000;
        tick;
    endtask

    task automatic test_reset_mid_wait;
        apply_reset;
        auto_a = 0;
        cli_req = 3'b100;
        tick;
        n_cmp++; if (mem_req_a !== 1'b1 || gidx_a !== 2'd2) begin n_bad++; $display("FAIL rstw_pre: req=%b idx=%0d want 1/2", mem_req_a, gidx_a); end
        tick;
        tick;
        tick;
        #2;
        rst = 1'b1;
        cli_req = 3'b000;
        #1;
        n_cmp++; if (mem_req_a !== 1'b0) begin n_bad++; $display("FAIL rstw_mem_req: got %b want 0", mem_req_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rstw_busy: got %b want 0", busy_a); end
        n_cmp++; if (gidx_a !== 2'd0) begin n_bad++; $display("FAIL rstw_grant_idx: got %0d want 0", gidx_a); end
        tick;
        rst = 1'b0;
        tick;
        man_ack_a = 1'b1;
        tick;
        man_ack_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            n_cmp++; if (done_a !== 3'b000 || busy_a !== 1'b0 || mem_req_a !== 1'b0) begin
                n_bad++; $display("FAIL rstw_late_ack: done=%b busy=%b req=%b want 000/0/0", done_a, busy_a, mem_req_a);
            end
        end
    endtask

    task automatic test_withdrawn;
        bit seen;
        seen = 1'b0;
        apply_reset;
        auto_a = 6;
        mem_rdata_a = 8'hC3;
        cli_we = 3'b000;
        cli_req = 3'b001;
        tick;
        cli_req = 3'b011;
        tick;
        cli_req = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (done_a != 3'b000) begin seen = 1'b1; break; end
        end
        n_cmp++; if (seen !== 1'b1 || done_a !== 3'b001) begin n_bad++; $display("FAIL wd_done: got %b want 001", done_a); end
        n_cmp++; if (rdata_a !== 8'hC3) begin n_bad++; $display("FAIL wd_rdata: got %h want c3", rdata_a); end
        tick;
        cli_req = 3'b000;
        for (int k = 0; k < 6; k++) begin
            tick;
            n_cmp++; if (busy_a !== 1'b0 || gidx_a !== 2'd0 || done_a !== 3'b000) begin
                n_bad++; $display("FAIL wd_no_grant: busy=%b idx=%0d done=%b want 0/0/000", busy_a, gidx_a, done_a);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_single_write;
        test_back_to_back;
        test_timeout;
        test_reset_mid_wait;
        test_withdrawn;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
